// File: rtl/pipe_ctrl_regs.sv
// Control-side pipeline latches (EX/MEM/WB), PC and IF/ID enables, and the
// data-memory wait freeze. Optional macro PIPE_PERF_CNT_EN adds perf counters.
module pipe_ctrl_regs #(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_wreg,
    input  logic                  id_mem2reg,
    input  logic                  id_wmem,
    input  logic                  id_jal,
    input  logic [REG_ADDR_W-1:0] id_regw_addr,
    input  logic                  stall,
    input  logic                  branch,
    input  logic                  dmem_busy,
    output logic                  exe_wreg,
    output logic                  exe_mem2reg,
    output logic                  exe_wmem,
    output logic                  exe_jal,
    output logic [REG_ADDR_W-1:0] exe_regw_addr,
    output logic                  mem_wreg,
    output logic                  mem_mem2reg,
    output logic                  mem_wmem,
    output logic [REG_ADDR_W-1:0] mem_regw_addr,
    output logic                  wb_wreg,
    output logic                  wb_mem2reg,
    output logic [REG_ADDR_W-1:0] wb_regw_addr,
    output logic                  pc_we,
    output logic                  ifid_we,
    output logic                  ifid_flush,
    output logic [1:0]            state,
    output logic                  mem_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [15:0]           perf_stall_cnt,
    output logic [15:0]           perf_flush_cnt,
    output logic [15:0]           perf_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_FLUSH      = 2'd3
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    state_t                  r_state;
    state_t                  w_act;

    logic                    r_ex_valid;
    logic                    r_ex_wreg;
    logic                    r_ex_mem2reg;
    logic                    r_ex_wmem;
    logic                    r_ex_jal;
    logic [REG_ADDR_W-1:0]   r_ex_regw_addr;

    logic                    r_mem_valid;
    logic                    r_mem_wreg;
    logic                    r_mem_mem2reg;
    logic                    r_mem_wmem;
    logic [REG_ADDR_W-1:0]   r_mem_regw_addr;

    logic                    r_wb_valid;
    logic                    r_wb_wreg;
    logic                    r_wb_mem2reg;
    logic [REG_ADDR_W-1:0]   r_wb_regw_addr;

    logic [7:0]              r_wait_cnt;
    logic                    r_mem_timeout;
    logic                    w_wait_hit;

    // State register: records the action taken on the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_act;
        end
    end

    // Next-state / action select: busy > stall > branch > normal.
    always_comb begin
        w_act = ST_RUN;
        if (dmem_busy) begin
            w_act = ST_MEM_WAIT;
        end else if (stall) begin
            w_act = ST_LOAD_STALL;
        end else if (branch) begin
            w_act = ST_FLUSH;
        end else begin
            w_act = ST_RUN;
        end
    end

    // Front-end enables follow the current action; forced low while in reset.
    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        if (!rst_n) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b0;
        end else begin
            case (w_act)
                ST_RUN: begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                end
                ST_FLUSH: begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b1;
                end
                ST_LOAD_STALL: begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                end
                ST_MEM_WAIT: begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                end
                default: begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    ifid_flush = 1'b0;
                end
            endcase
        end
    end

    // EX stage latch: holds on freeze, takes a bubble on stall, else loads ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_wreg      <= 1'b0;
            r_ex_mem2reg   <= 1'b0;
            r_ex_wmem      <= 1'b0;
            r_ex_jal       <= 1'b0;
            r_ex_regw_addr <= {REG_ADDR_W{1'b0}};
        end else begin
            case (w_act)
                ST_RUN, ST_FLUSH: begin
                    r_ex_valid     <= 1'b1;
                    r_ex_wreg      <= id_wreg;
                    r_ex_mem2reg   <= id_mem2reg;
                    r_ex_wmem      <= id_wmem;
                    r_ex_jal       <= id_jal;
                    r_ex_regw_addr <= id_regw_addr;
                end
                ST_LOAD_STALL: begin
                    r_ex_valid     <= 1'b0;
                    r_ex_wreg      <= 1'b0;
                    r_ex_mem2reg   <= 1'b0;
                    r_ex_wmem      <= 1'b0;
                    r_ex_jal       <= 1'b0;
                    r_ex_regw_addr <= {REG_ADDR_W{1'b0}};
                end
                default: begin
                    r_ex_valid <= r_ex_valid;
                end
            endcase
        end
    end

    // MEM stage latch: holds on freeze, otherwise takes EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid     <= 1'b0;
            r_mem_wreg      <= 1'b0;
            r_mem_mem2reg   <= 1'b0;
            r_mem_wmem      <= 1'b0;
            r_mem_regw_addr <= {REG_ADDR_W{1'b0}};
        end else if (w_act != ST_MEM_WAIT) begin
            r_mem_valid     <= r_ex_valid;
            r_mem_wreg      <= r_ex_wreg;
            r_mem_mem2reg   <= r_ex_mem2reg;
            r_mem_wmem      <= r_ex_wmem;
            r_mem_regw_addr <= r_ex_regw_addr;
        end else begin
            r_mem_valid <= r_mem_valid;
        end
    end

    // WB stage latch: invalidated during freeze so the register file is written once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid     <= 1'b0;
            r_wb_wreg      <= 1'b0;
            r_wb_mem2reg   <= 1'b0;
            r_wb_regw_addr <= {REG_ADDR_W{1'b0}};
        end else if (w_act == ST_MEM_WAIT) begin
            r_wb_valid <= 1'b0;
        end else begin
            r_wb_valid     <= r_mem_valid;
            r_wb_wreg      <= r_mem_wreg;
            r_wb_mem2reg   <= r_mem_mem2reg;
            r_wb_regw_addr <= r_mem_regw_addr;
        end
    end

    // Timeout fires on the busy edge that brings the run length up to MAX_WAIT.
    assign w_wait_hit = (r_wait_cnt >= (MAX_WAIT_C - 8'd1));

    // Busy-run counter (saturating) and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
        end else if (dmem_busy) begin
            if (r_wait_cnt < MAX_WAIT_C) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end
            if (w_wait_hit) begin
                r_mem_timeout <= 1'b1;
            end else begin
                r_mem_timeout <= r_mem_timeout;
            end
        end else begin
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= r_mem_timeout;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] r_perf_stall;
    logic [15:0] r_perf_flush;
    logic [15:0] r_perf_wait;

    // Saturating event counters, one per non-run action.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= 16'd0;
            r_perf_flush <= 16'd0;
            r_perf_wait  <= 16'd0;
        end else begin
            case (w_act)
                ST_LOAD_STALL: r_perf_stall <= sat_inc16(r_perf_stall);
                ST_FLUSH:      r_perf_flush <= sat_inc16(r_perf_flush);
                ST_MEM_WAIT:   r_perf_wait  <= sat_inc16(r_perf_wait);
                default:       r_perf_stall <= r_perf_stall;
            endcase
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
    assign perf_wait_cnt  = r_perf_wait;
`endif

    assign exe_wreg      = r_ex_valid & r_ex_wreg;
    assign exe_mem2reg   = r_ex_valid & r_ex_mem2reg;
    assign exe_wmem      = r_ex_valid & r_ex_wmem;
    assign exe_jal       = r_ex_valid & r_ex_jal;
    assign exe_regw_addr = r_ex_regw_addr & {REG_ADDR_W{r_ex_valid}};

    assign mem_wreg      = r_mem_valid & r_mem_wreg;
    assign mem_mem2reg   = r_mem_valid & r_mem_mem2reg;
    assign mem_wmem      = r_mem_valid & r_mem_wmem;
    assign mem_regw_addr = r_mem_regw_addr & {REG_ADDR_W{r_mem_valid}};

    assign wb_wreg       = r_wb_valid & r_wb_wreg;
    assign wb_mem2reg    = r_wb_valid & r_wb_mem2reg;
    assign wb_regw_addr  = r_wb_regw_addr & {REG_ADDR_W{r_wb_valid}};

    assign state         = r_state;
    assign mem_timeout   = r_mem_timeout;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Directed-vector bench for pipe_ctrl_regs with hand-computed expectations.
module tb_pipe_ctrl_regs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_wreg, id_mem2reg, id_wmem, id_jal;
    logic [4:0] id_regw_addr;
    logic       stall, branch, dmem_busy;
    logic       exe_wreg, exe_mem2reg, exe_wmem, exe_jal;
    logic [4:0] exe_regw_addr;
    logic       mem_wreg, mem_mem2reg, mem_wmem;
    logic [4:0] mem_regw_addr;
    logic       wb_wreg, wb_mem2reg;
    logic [4:0] wb_regw_addr;
    logic       pc_we, ifid_we, ifid_flush;
    logic [1:0] state;
    logic       mem_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] perf_stall_cnt, perf_flush_cnt, perf_wait_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl_regs #(.REG_ADDR_W(5), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_wreg(id_wreg), .id_mem2reg(id_mem2reg), .id_wmem(id_wmem),
        .id_jal(id_jal), .id_regw_addr(id_regw_addr),
        .stall(stall), .branch(branch), .dmem_busy(dmem_busy),
        .exe_wreg(exe_wreg), .exe_mem2reg(exe_mem2reg), .exe_wmem(exe_wmem),
        .exe_jal(exe_jal), .exe_regw_addr(exe_regw_addr),
        .mem_wreg(mem_wreg), .mem_mem2reg(mem_mem2reg), .mem_wmem(mem_wmem),
        .mem_regw_addr(mem_regw_addr),
        .wb_wreg(wb_wreg), .wb_mem2reg(wb_mem2reg), .wb_regw_addr(wb_regw_addr),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .state(state), .mem_timeout(mem_timeout)
`ifdef PIPE_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
        .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs are then changed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic w, input logic m2r, input logic wm,
                            input logic j, input logic [4:0] a);
        id_wreg = w; id_mem2reg = m2r; id_wmem = wm; id_jal = j; id_regw_addr = a;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch = 1'b0; dmem_busy = 1'b0;
        drive_id(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Reset held with toggling stimulus.
        for (int i = 0; i < 3; i++) begin
            branch = 1'b1;
            drive_id(~id_wreg, 1'b1, 1'b0, 1'b0, 5'd9);
            tick();
        end
        #1;
        check_vec("rst_exe_wreg", 32'(exe_wreg), 32'd0);
        check_vec("rst_exe_addr", 32'(exe_regw_addr), 32'd0);
        check_vec("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        check_vec("rst_pc_we", 32'(pc_we), 32'd0);
        check_vec("rst_ifid_we", 32'(ifid_we), 32'd0);
        check_vec("rst_flush", 32'(ifid_flush), 32'd0);
        check_vec("rst_state", 32'(state), 32'd0);
        check_vec("rst_timeout", 32'(mem_timeout), 32'd0);
        branch = 1'b0;
        drive_id(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        rst_n = 1'b1;
        #1;
        check_vec("rel_pc_we", 32'(pc_we), 32'd1);
        check_vec("rel_ifid_we", 32'(ifid_we), 32'd1);
        tick();

        // Load-use: lw r8 enters EX, then one stall cycle.
        drive_id(1'b1, 1'b1, 1'b0, 1'b0, 5'd8);
        tick();
        check_vec("lw_exe_addr", 32'(exe_regw_addr), 32'd8);
        check_vec("lw_exe_m2r", 32'(exe_mem2reg), 32'd1);
        drive_id(1'b1, 1'b0, 1'b0, 1'b0, 5'd9);
        stall = 1'b1;
        #1;
        check_vec("stall_pc_we", 32'(pc_we), 32'd0);
        check_vec("stall_ifid_we", 32'(ifid_we), 32'd0);
        tick();
        check_vec("stall_exe_wreg", 32'(exe_wreg), 32'd0);
        check_vec("stall_exe_addr", 32'(exe_regw_addr), 32'd0);
        check_vec("stall_mem_addr", 32'(mem_regw_addr), 32'd8);
        check_vec("stall_mem_m2r", 32'(mem_mem2reg), 32'd1);
        check_vec("stall_state", 32'(state), 32'd1);
        stall = 1'b0;
        tick();
        check_vec("res_exe_addr", 32'(exe_regw_addr), 32'd9);
        check_vec("res_mem_wreg", 32'(mem_wreg), 32'd0);
        check_vec("res_wb_addr", 32'(wb_regw_addr), 32'd8);
        check_vec("res_wb_m2r", 32'(wb_mem2reg), 32'd1);
        check_vec("res_state", 32'(state), 32'd0);

        // Branch with add r3 in ID.
        drive_id(1'b1, 1'b0, 1'b0, 1'b0, 5'd3);
        branch = 1'b1;
        #1;
        check_vec("br_flush", 32'(ifid_flush), 32'd1);
        check_vec("br_pc_we", 32'(pc_we), 32'd1);
        tick();
        check_vec("br_state", 32'(state), 32'd3);
        check_vec("br_exe_addr", 32'(exe_regw_addr), 32'd3);
        check_vec("br_mem_addr", 32'(mem_regw_addr), 32'd9);
        branch = 1'b0;
        drive_id(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        check_vec("post_br_flush", 32'(ifid_flush), 32'd0);
        tick();
        check_vec("nop_exe_wreg", 32'(exe_wreg), 32'd0);
        check_vec("nop_state", 32'(state), 32'd0);
        check_vec("nop_mem_addr", 32'(mem_regw_addr), 32'd3);

        // Fill: add r6, sw, add r5 -> EX=r5, MEM=sw, WB=r6.
        drive_id(1'b1, 1'b0, 1'b0, 1'b0, 5'd6);
        tick();
        drive_id(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        tick();
        drive_id(1'b1, 1'b0, 1'b0, 1'b0, 5'd5);
        tick();
        check_vec("fill_wb_wreg", 32'(wb_wreg), 32'd1);
        check_vec("fill_wb_addr", 32'(wb_regw_addr), 32'd6);
        check_vec("fill_mem_wmem", 32'(mem_wmem), 32'd1);

        // Freeze three cycles with add r7 waiting in ID.
        drive_id(1'b1, 1'b0, 1'b0, 1'b0, 5'd7);
        dmem_busy = 1'b1;
        #1;
        check_vec("frz_pc_we", 32'(pc_we), 32'd0);
        check_vec("frz_ifid_we", 32'(ifid_we), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("frz_mem_wmem", 32'(mem_wmem), 32'd1);
            check_vec("frz_exe_addr", 32'(exe_regw_addr), 32'd5);
            check_vec("frz_wb_wreg", 32'(wb_wreg), 32'd0);
            check_vec("frz_state", 32'(state), 32'd2);
        end
        check_vec("frz_timeout", 32'(mem_timeout), 32'd0);
        dmem_busy = 1'b0;
        #1;
        check_vec("unfrz_pc_we", 32'(pc_we), 32'd1);
        tick();
        check_vec("unfrz_exe_addr", 32'(exe_regw_addr), 32'd7);
        check_vec("unfrz_mem_addr", 32'(mem_regw_addr), 32'd5);
        check_vec("unfrz_mem_wmem", 32'(mem_wmem), 32'd0);
        check_vec("unfrz_wb_wreg", 32'(wb_wreg), 32'd0);
        check_vec("unfrz_state", 32'(state), 32'd0);

        // Timeout after 15 consecutive busy cycles.
        drive_id(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        dmem_busy = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check_vec("to_before", 32'(mem_timeout), 32'd0);
        tick();
        check_vec("to_set", 32'(mem_timeout), 32'd1);
        tick();
        dmem_busy = 1'b0;
        tick();
        tick();
        check_vec("to_sticky", 32'(mem_timeout), 32'd1);
        check_vec("to_state_run", 32'(state), 32'd0);

        // Reset in the middle of a freeze.
        dmem_busy = 1'b1;
        tick();
        check_vec("mid_state", 32'(state), 32'd2);
        rst_n = 1'b0;
        #1;
        check_vec("mid_rst_state", 32'(state), 32'd0);
        check_vec("mid_rst_timeout", 32'(mem_timeout), 32'd0);
        check_vec("mid_rst_pc_we", 32'(pc_we), 32'd0);
        dmem_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check_vec("mid_rel_pc_we", 32'(pc_we), 32'd1);
        tick();

        // Priority: busy + stall + branch with jal r31 in ID.
        drive_id(1'b1, 1'b0, 1'b0, 1'b1, 5'd31);
        dmem_busy = 1'b1; stall = 1'b1; branch = 1'b1;
        #1;
        check_vec("pri_flush", 32'(ifid_flush), 32'd0);
        check_vec("pri_pc_we", 32'(pc_we), 32'd0);
        tick();
        check_vec("pri_state_wait", 32'(state), 32'd2);
        dmem_busy = 1'b0;
        #1;
        check_vec("pri_stall_flush", 32'(ifid_flush), 32'd0);
        tick();
        check_vec("pri_state_stall", 32'(state), 32'd1);
        check_vec("pri_exe_wreg", 32'(exe_wreg), 32'd0);
        stall = 1'b0;
        #1;
        check_vec("pri_br_flush", 32'(ifid_flush), 32'd1);
        tick();
        check_vec("pri_state_flush", 32'(state), 32'd3);
        check_vec("pri_exe_addr", 32'(exe_regw_addr), 32'd31);
        check_vec("pri_exe_jal", 32'(exe_jal), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
